// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op encoding used by the controller and the unit,
// plus the result payload passed from the arithmetic core to the top.
package mdu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned CNT_W  = 4;

  localparam logic [OP_W-1:0] MDU_MULT  = OP_W'(0);
  localparam logic [OP_W-1:0] MDU_MULTU = OP_W'(1);
  localparam logic [OP_W-1:0] MDU_DIV   = OP_W'(2);
  localparam logic [OP_W-1:0] MDU_DIVU  = OP_W'(3);
  localparam logic [OP_W-1:0] MDU_MTHI  = OP_W'(4);
  localparam logic [OP_W-1:0] MDU_MTLO  = OP_W'(5);

  typedef struct packed {
    logic              wr;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } mdu_res_t;

  function automatic logic is_mul_op(logic [OP_W-1:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic is_div_op(logic [OP_W-1:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_core.sv
// Combinational MDU datapath: 64-bit product and quotient/remainder from the
// latched operands. Division by zero produces no write.
import mdu_pkg::*;

module mdu_core (
  input  logic [OP_W-1:0]   op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output mdu_res_t          res_c_o
);

  logic                  sgn;
  logic [2*DATA_W-1:0]   a_ext;
  logic [2*DATA_W-1:0]   b_ext;
  logic [2*DATA_W-1:0]   prod;
  logic                  a_neg;
  logic                  b_neg;
  logic [DATA_W-1:0]     a_mag;
  logic [DATA_W-1:0]     b_mag;
  logic                  div_by0;
  logic [DATA_W-1:0]     dvsr;
  logic [DATA_W-1:0]     q_mag;
  logic [DATA_W-1:0]     r_mag;
  logic [DATA_W-1:0]     quot;
  logic [DATA_W-1:0]     rem;

  // Signed division runs on magnitudes so that 0x80000000 / -1 wraps cleanly.
  always_comb begin
    sgn     = (op_i == MDU_MULT) || (op_i == MDU_DIV);
    a_ext   = sgn ? {{DATA_W{a_i[DATA_W-1]}}, a_i} : {{DATA_W{1'b0}}, a_i};
    b_ext   = sgn ? {{DATA_W{b_i[DATA_W-1]}}, b_i} : {{DATA_W{1'b0}}, b_i};
    prod    = a_ext * b_ext;

    a_neg   = sgn & a_i[DATA_W-1];
    b_neg   = sgn & b_i[DATA_W-1];
    a_mag   = a_neg ? (DATA_W'(0) - a_i) : a_i;
    b_mag   = b_neg ? (DATA_W'(0) - b_i) : b_i;
    div_by0 = (b_i == '0);
    dvsr    = div_by0 ? DATA_W'(1) : b_mag;
    q_mag   = a_mag / dvsr;
    r_mag   = a_mag % dvsr;
    quot    = (a_neg ^ b_neg) ? (DATA_W'(0) - q_mag) : q_mag;
    rem     = a_neg ? (DATA_W'(0) - r_mag) : r_mag;

    res_c_o = '0;
    if (is_mul_op(op_i)) begin
      res_c_o.wr = 1'b1;
      res_c_o.hi = prod[2*DATA_W-1:DATA_W];
      res_c_o.lo = prod[DATA_W-1:0];
    end else if (is_div_op(op_i)) begin
      res_c_o.wr = !div_by0;
      res_c_o.hi = rem;
      res_c_o.lo = quot;
    end
  end

endmodule

// File: rtl/mdu.sv
// EX-stage multiply/divide unit: IDLE/RUN sequencer, busy counter and the
// architectural HI/LO registers. Results land only on the final busy edge.
import mdu_pkg::*;

module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              busy,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO
);

  typedef enum logic [0:0] {IDLE, RUN} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic              busy_q;
  mdu_res_t          res_c;

  mdu_core u_core (
    .op_i    (op_q),
    .a_i     (a_q),
    .b_i     (b_q),
    .res_c_o (res_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (op_valid) begin
            if (is_mul_op(op) || is_div_op(op)) begin
              a_q     <= A;
              b_q     <= B;
              op_q    <= op;
              cnt_q   <= is_mul_op(op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
              busy_q  <= 1'b1;
              state_q <= RUN;
            end else if (op == MDU_MTHI) begin
              hi_q <= A;
            end else if (op == MDU_MTLO) begin
              lo_q <= A;
            end
          end
        end
        RUN: begin
          // Requests arriving here are dropped; the hazard unit should prevent them.
          if (cnt_q == CNT_W'(1)) begin
            if (res_c.wr) begin
              hi_q <= res_c.hi;
              lo_q <= res_c.lo;
            end
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed plan cases plus random traffic checked
// each cycle against an arithmetic reference model.
module tb_mdu;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  int          m_cnt;
  logic        m_wr;
  logic [31:0] m_hi, m_lo, m_phi, m_plo;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .op       (op),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .HI       (HI),
    .LO       (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_calc(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                   output logic wr, output logic [31:0] hi, output logic [31:0] lo);
    longint          sa, sb, p, q, r;
    longint unsigned ua, ub, up, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    wr = 1'b1;
    hi = '0;
    lo = '0;
    case (o)
      3'd0: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      3'd1: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
      3'd2: if (b == 0) wr = 1'b0;
            else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
      3'd3: if (b == 0) wr = 1'b0;
            else begin uq = ua / ub; ur = ua % ub; lo = uq[31:0]; hi = ur[31:0]; end
      default: wr = 1'b0;
    endcase
  endfunction

  // One clock edge: advance model with the inputs seen at the edge, then compare.
  task automatic step();
    @(posedge clk);
    if (reset) begin
      m_cnt = 0; m_hi = '0; m_lo = '0;
    end else if (m_cnt > 0) begin
      if (m_cnt == 1 && m_wr) begin m_hi = m_phi; m_lo = m_plo; end
      m_cnt--;
    end else if (op_valid) begin
      if (op < 3'd4) begin
        ref_calc(op, A, B, m_wr, m_phi, m_plo);
        m_cnt = (op < 3'd2) ? int'(MC) : int'(DC);
      end else if (op == 3'd4) m_hi = A;
      else if (op == 3'd5) m_lo = A;
    end
    #1;
    check("busy", 32'(busy), 32'(m_cnt > 0));
    check("HI", HI, m_hi);
    check("LO", LO, m_lo);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1; op = o; A = a; B = b;
    step();
    op_valid = 1'b0; op = 3'd7; A = '0; B = '0;
  endtask

  // Count remaining busy cycles, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      step();
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    m_cnt = 0; m_wr = 1'b0; m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0;
    reset = 1'b1; op_valid = 1'b0; op = 3'd7; A = '0; B = '0;
    step();
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_hi", HI, 32'h0);
    check("rst_lo", LO, 32'h0);

    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    check("mult_lat", 32'(n), 32'd5);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(n);
    check("multu_lat", 32'(n), 32'd5);
    check("multu_hi", HI, 32'hFFFF_FFFE);
    check("multu_lo", LO, 32'h0000_0001);

    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    check("div_lat", 32'(n), 32'd10);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);
    issue(3'd3, 32'd7, 32'd2);
    wait_idle(n);
    check("divu_lo", LO, 32'd3);
    check("divu_hi", HI, 32'd1);

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    check("divovf_lo", LO, 32'h8000_0000);
    check("divovf_hi", HI, 32'h0);

    issue(3'd4, 32'h1234_5678, 32'h0);
    check("mthi_hi", HI, 32'h1234_5678);
    check("mthi_busy", 32'(busy), 32'h0);
    issue(3'd5, 32'h9ABC_DEF0, 32'h0);
    check("mtlo_lo", LO, 32'h9ABC_DEF0);
    check("mtlo_busy", 32'(busy), 32'h0);
    issue(3'd3, 32'd99, 32'h0);
    wait_idle(n);
    check("dz_lat", 32'(n), 32'd10);
    check("dz_hi", HI, 32'h1234_5678);
    check("dz_lo", LO, 32'h9ABC_DEF0);

    issue(3'd0, 32'd7, 32'd9);
    step();
    issue(3'd5, 32'hDEAD_BEEF, 32'h0);
    issue(3'd2, 32'd100, 32'd3);
    wait_idle(n);
    check("ign_lat", 32'(n), 32'd2);
    check("ign_lo", LO, 32'd63);
    check("ign_hi", HI, 32'd0);

    issue(3'd2, 32'd100, 32'd7);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_hi", HI, 32'h0);
    check("abort_lo", LO, 32'h0);
    repeat (12) step();
    issue(3'd0, 32'd2, 32'd3);
    wait_idle(n);
    check("post_lo", LO, 32'd6);
    check("post_hi", HI, 32'd0);

    issue(3'd6, 32'h5555_5555, 32'h1);
    issue(3'd7, 32'hAAAA_AAAA, 32'h1);

    for (int i = 0; i < 800; i++) begin
      reset    = ($urandom_range(0, 99) == 0);
      op_valid = ($urandom_range(0, 2) != 0);
      op       = 3'($urandom_range(0, 7));
      A        = pick();
      B        = pick();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
